// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the 8-bit core.
// Optional retired-instruction counter enabled by defining CTRL_SEQ_PERF_EN.
module ctrl_seq #(
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned PERF_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run_i,
    output logic                imem_req_o,
    input  logic                imem_valid_i,
    input  logic [5:0]          opcode_i,
    input  logic                zero_i,
    output logic                sel_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                load_a_o,
    output logic                load_b_o,
    output logic                pc_inc_o,
    output logic                pc_load_o,
    output logic                busy_o,
    output logic [PERF_W-1:0]   retired_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb
    } state_e;

    localparam logic [1:0] ClsAluA = 2'b00;
    localparam logic [1:0] ClsAluB = 2'b01;
    localparam logic [1:0] ClsJmp  = 2'b10;

    state_e     r_state, w_state_d;
    // IR holds the immediate bit inverted, so IR[3] is sel_b directly and resets to 0.
    logic [5:0] r_ir, w_ir_d;
    logic       r_z, w_z_d;
    // Strobe vector: {load_a, load_b, pc_inc, pc_load}
    logic [3:0] r_strb, w_strb_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_strb  <= '0;
        end else begin
            r_state <= w_state_d;
            r_ir    <= w_ir_d;
            r_z     <= w_z_d;
            r_strb  <= w_strb_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ir_d    = r_ir;
        w_z_d     = r_z;
        w_strb_d  = 4'b0000;
        case (r_state)
            StIdle: begin
                if (run_i) w_state_d = StFetch;
            end
            StFetch: begin
                if (imem_valid_i) begin
                    w_state_d = StDecode;
                    w_ir_d    = {opcode_i[5:4], ~opcode_i[3], opcode_i[2:0]};
                end
            end
            StDecode: begin
                w_z_d     = zero_i;
                w_state_d = StExec;
            end
            StExec: begin
                w_state_d = StWb;
                case (r_ir[5:4])
                    ClsAluA: w_strb_d = 4'b1010;
                    ClsAluB: w_strb_d = 4'b0110;
                    ClsJmp:  w_strb_d = 4'b0001;
                    default: w_strb_d = r_z ? 4'b0001 : 4'b0010;
                endcase
            end
            StWb: begin
                w_state_d = run_i ? StFetch : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign imem_req_o = (r_state == StFetch);
    assign busy_o     = (r_state != StIdle);
    assign sel_b_o    = r_ir[3];
    assign alu_op_o   = ALU_OP_W'(r_ir[2:0]);
    assign {load_a_o, load_b_o, pc_inc_o, pc_load_o} = r_strb;

`ifdef CTRL_SEQ_PERF_EN
    logic [PERF_W-1:0] r_retired;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retired <= '0;
        end else if (r_state == StWb) begin
            r_retired <= r_retired + PERF_W'(1);
        end
    end

    assign retired_o = r_retired;
`else
    assign retired_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed cases followed by randomized instructions,
// each cycle compared against an instruction-level reference model.
module tb_ctrl_seq;

    localparam int PW = 4;
`ifdef CTRL_SEQ_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          run_i;
    logic          imem_req_o;
    logic          imem_valid_i;
    logic [5:0]    opcode_i;
    logic          zero_i;
    logic          sel_b_o;
    logic [2:0]    alu_op_o;
    logic          load_a_o;
    logic          load_b_o;
    logic          pc_inc_o;
    logic          pc_load_o;
    logic          busy_o;
    logic [PW-1:0] retired_o;

    always #5 clk = ~clk;

    ctrl_seq #(
        .ALU_OP_W (3),
        .PERF_W   (PW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .run_i        (run_i),
        .imem_req_o   (imem_req_o),
        .imem_valid_i (imem_valid_i),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .sel_b_o      (sel_b_o),
        .alu_op_o     (alu_op_o),
        .load_a_o     (load_a_o),
        .load_b_o     (load_b_o),
        .pc_inc_o     (pc_inc_o),
        .pc_load_o    (pc_load_o),
        .busy_o       (busy_o),
        .retired_o    (retired_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: operand controls of the last decoded instruction and instructions retired.
    logic       m_sel;
    logic [2:0] m_alu;
    int         m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ret();
        return PerfEn ? 32'(m_ret % (1 << PW)) : 32'd0;
    endfunction

    // WB strobes {load_a, load_b, pc_inc, pc_load} by instruction class.
    function automatic logic [3:0] wb_strobes(input logic [5:0] op, input logic z);
        case (op[5:4])
            2'd0:    return 4'b1010;
            2'd1:    return 4'b0110;
            2'd2:    return 4'b0001;
            default: return z ? 4'b0001 : 4'b0010;
        endcase
    endfunction

    task automatic check_outs(input logic req, input logic busy, input logic [3:0] strb);
        chk("imem_req", 32'(imem_req_o), 32'(req));
        chk("busy", 32'(busy_o), 32'(busy));
        chk("sel_b", 32'(sel_b_o), 32'(m_sel));
        chk("alu_op", 32'(alu_op_o), 32'(m_alu));
        chk("strobes", 32'({load_a_o, load_b_o, pc_inc_o, pc_load_o}), 32'(strb));
        chk("retired", 32'(retired_o), exp_ret());
    endtask

    // One cycle in IDLE; run decides whether the next cycle is a fetch.
    task automatic idle_cycle(input logic run);
        check_outs(1'b0, 1'b0, 4'b0000);
        run_i        = run;
        imem_valid_i = 1'($urandom);
        opcode_i     = 6'($urandom);
        zero_i       = 1'($urandom);
        @(negedge clk);
    endtask

    // Entered at the first fetch cycle. Valid arrives after `delay` cycles; the instruction
    // then spends decode, exec and writeback cycles. spur drives valid outside fetch.
    task automatic run_instr(input logic [5:0] op, input int delay, input logic z,
                             input logic run_after, input logic spur);
        int n = delay + 4;
        for (int t = 0; t < n; t++) begin
            if (t == delay + 1) begin
                m_sel = ~op[3];
                m_alu = op[2:0];
            end
            check_outs(t <= delay, 1'b1, (t == n - 1) ? wb_strobes(op, z) : 4'b0000);
            run_i  = (t == n - 1) ? run_after : 1'($urandom);
            zero_i = (t == delay + 1) ? z : 1'($urandom);
            if (t <= delay) begin
                imem_valid_i = (t == delay);
                opcode_i     = (t == delay) ? op : 6'($urandom);
            end else begin
                imem_valid_i = spur;
                opcode_i     = 6'($urandom);
            end
            if (t == n - 1) m_ret++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        logic       ra;
        rst_ni       = 1'b0;
        run_i        = 1'b0;
        imem_valid_i = 1'b0;
        opcode_i     = '0;
        zero_i       = 1'b0;
        m_sel        = 1'b0;
        m_alu        = '0;
        m_ret        = 0;

        repeat (2) @(negedge clk);
        check_outs(1'b0, 1'b0, 4'b0000);
        rst_ni = 1'b1;
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // ALU->A immediate, ALU->B register, JZ taken / not taken
        run_instr(6'b001010, 0, 1'b0, 1'b1, 1'b0);
        run_instr(6'b010101, 0, 1'b0, 1'b1, 1'b0);
        run_instr(6'b110000, 0, 1'b1, 1'b1, 1'b0);
        run_instr(6'b110000, 0, 1'b0, 1'b1, 1'b0);
        // JMP with valid delayed 3 cycles and spurious valid pulses afterwards
        run_instr(6'b101111, 3, 1'b0, 1'b1, 1'b1);
        // run dropped: finishes, then stays idle without requesting
        run_instr(6'b000001, 0, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Reset asserted while in DECODE clears everything at once
        check_outs(1'b1, 1'b1, 4'b0000);
        run_i        = 1'b1;
        imem_valid_i = 1'b1;
        opcode_i     = 6'b011110;
        @(negedge clk);
        m_sel = 1'b0;
        m_alu = 3'b110;
        check_outs(1'b0, 1'b1, 4'b0000);
        #2 rst_ni = 1'b0;
        #1;
        m_sel = 1'b0;
        m_alu = '0;
        m_ret = 0;
        check_outs(1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        rst_ni = 1'b1;
        run_i  = 1'b0;
        @(negedge clk);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Randomized instructions; more than 2^PW of them so the counter wraps
        for (int i = 0; i < 40; i++) begin
            op = 6'($urandom);
            ra = (i == 39) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            run_instr(op, int'($urandom_range(0, 3)), 1'($urandom), ra, 1'($urandom));
            if (!ra) begin
                repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
                if (i != 39) idle_cycle(1'b1);
            end
        end
        idle_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
